// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for the single-port data RAM
// Handles strobe generation, alignment/range checks and load extension.
module dmem_arbiter #(
  parameter int                         ADDRESS_LENGTH = 32,
  parameter logic [ADDRESS_LENGTH-1:0]  ADDR_MAX       = 32'h1FFFF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          req_i,
  input  logic [1:0]                          we_i,
  input  logic [1:0][1:0]                     size_i,
  input  logic [1:0]                          uext_i,
  input  logic [1:0][ADDRESS_LENGTH-1:0]      addr_i,
  input  logic [1:0][ADDRESS_LENGTH-1:0]      wdata_i,
  output logic [1:0]                          gnt_o,
  output logic [1:0]                          rvalid_o,
  output logic [1:0]                          err_o,
  output logic [1:0][ADDRESS_LENGTH-1:0]      rdata_o,
  output logic [ADDRESS_LENGTH-1:0]           ram_a,
  output logic [ADDRESS_LENGTH-1:0]           ram_wd,
  output logic                                ram_sb,
  output logic                                ram_sh,
  output logic                                ram_sw,
  input  logic [ADDRESS_LENGTH-1:0]           ram_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                    state, state_nxt;
  logic                      rr;
  logic                      grant;
  logic                      sel_port;

  logic                      lat_port;
  logic                      lat_we;
  logic [1:0]                lat_size;
  logic                      lat_uext;
  logic [ADDRESS_LENGTH-1:0] lat_addr;
  logic [ADDRESS_LENGTH-1:0] lat_wdata;

  logic [ADDRESS_LENGTH:0]   span;
  logic [ADDRESS_LENGTH:0]   last_byte;
  logic                      acc_err;
  logic                      in_access;
  logic                      do_store;
  logic [ADDRESS_LENGTH-1:0] load_data;

  // rr names the port that wins when both request
  always_comb begin
    state_nxt = state;
    gnt_o     = '0;
    grant     = 1'b0;
    sel_port  = rr;
    case (state)
      IDLE: begin
        if (|req_i) begin
          grant     = 1'b1;
          sel_port  = (req_i == 2'b11) ? rr : req_i[1];
          gnt_o[sel_port] = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_uext  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr        <= ~sel_port;
        lat_port  <= sel_port;
        lat_we    <= we_i[sel_port];
        lat_size  <= size_i[sel_port];
        lat_uext  <= uext_i[sel_port];
        lat_addr  <= addr_i[sel_port];
        lat_wdata <= wdata_i[sel_port];
      end
    end
  end

  // Range check is done one bit wider so an access near 2^32 cannot wrap
  always_comb begin
    span = '0;
    case (lat_size)
      2'b01:   span[1:0] = 2'd1;
      2'b10:   span[1:0] = 2'd3;
      default: span[1:0] = 2'd0;
    endcase
    last_byte = {1'b0, lat_addr} + span;
    acc_err   = (lat_size == 2'b11)
              | ((lat_size == 2'b01) & lat_addr[0])
              | ((lat_size == 2'b10) & (lat_addr[1:0] != 2'b00))
              | (last_byte > {1'b0, ADDR_MAX});
  end

  assign in_access = (state == ACCESS);
  assign do_store  = in_access & lat_we & ~acc_err;
  assign ram_sb    = do_store & (lat_size == 2'b00);
  assign ram_sh    = do_store & (lat_size == 2'b01);
  assign ram_sw    = do_store & (lat_size == 2'b10);
  assign ram_a     = lat_addr;
  assign ram_wd    = lat_wdata;

  always_comb begin
    case (lat_size)
      2'b00:   load_data = {{(ADDRESS_LENGTH-8){~lat_uext & ram_rd[7]}}, ram_rd[7:0]};
      2'b01:   load_data = {{(ADDRESS_LENGTH-16){~lat_uext & ram_rd[15]}}, ram_rd[15:0]};
      default: load_data = ram_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
      if (in_access) begin
        rvalid_o[lat_port] <= 1'b1;
        err_o[lat_port]    <= acc_err;
        rdata_o[lat_port]  <= (acc_err | lat_we) ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a byte-array RAM
module tb_dmem_arbiter;

  localparam int MEMSZ = 32'h20000;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_i, we_i, uext_i;
  logic [1:0][1:0]  size_i;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [1:0]       gnt_o, rvalid_o, err_o;
  logic [1:0][31:0] rdata_o;
  logic [31:0]      ram_a, ram_wd, ram_rd;
  logic             ram_sb, ram_sh, ram_sw;

  logic [7:0] mem     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          p;
    logic        we;
    logic [1:0]  sz;
    logic        ux;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  dmem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .we_i     (we_i),
    .size_i   (size_i),
    .uext_i   (uext_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .err_o    (err_o),
    .rdata_o  (rdata_o),
    .ram_a    (ram_a),
    .ram_wd   (ram_wd),
    .ram_sb   (ram_sb),
    .ram_sh   (ram_sh),
    .ram_sw   (ram_sw),
    .ram_rd   (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < MEMSZ) ? mem[a] : 8'h00;
  endfunction

  always_comb ram_rd = {rb(ram_a + 32'd3), rb(ram_a + 32'd2), rb(ram_a + 32'd1), rb(ram_a)};

  always @(posedge clk) begin
    if (ram_sb && ram_a < MEMSZ) mem[ram_a] <= ram_wd[7:0];
    if (ram_sh && ram_a + 1 < MEMSZ) begin
      mem[ram_a]     <= ram_wd[7:0];
      mem[ram_a + 1] <= ram_wd[15:8];
    end
    if (ram_sw && ram_a + 3 < MEMSZ) begin
      mem[ram_a]     <= ram_wd[7:0];
      mem[ram_a + 1] <= ram_wd[15:8];
      mem[ram_a + 2] <= ram_wd[23:16];
      mem[ram_a + 3] <= ram_wd[31:24];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: access legality and data computed from byte counts and integer arithmetic
  task automatic ref_model(input logic we, input logic [1:0] sz, input logic ux,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd);
    int     n;
    longint v, ea;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea = {32'd0, a};
    e  = (sz == 2'd3) || ((ea % n) != 0) || (ea + n - 1 > 64'h1FFFF);
    rd = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if (!ux && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic do_access(input string nm, input int p, input logic we, input logic [1:0] sz,
                           input logic ux, input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd);
    int         t;
    logic [2:0] exp_strb;
    exp_strb = (we && !exp_err) ? ((sz == 2'd0) ? 3'b001 : (sz == 2'd1) ? 3'b010 : 3'b100) : 3'b000;
    @(negedge clk);
    we_i[p] = we; size_i[p] = sz; uext_i[p] = ux; addr_i[p] = a; wdata_i[p] = wd;
    req_i[p] = 1'b1;
    t = 0;
    #1;
    while (!gnt_o[p] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({nm, ".gnt"}, {30'd0, gnt_o}, 32'd1 << p);
    if (!gnt_o[p]) begin
      req_i[p] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_i[p] = 1'b0;
    @(negedge clk);
    chk({nm, ".strb"}, {29'd0, ram_sw, ram_sh, ram_sb}, {29'd0, exp_strb});
    chk({nm, ".early_rvalid"}, {30'd0, rvalid_o}, 32'd0);
    @(negedge clk);
    chk({nm, ".rvalid"}, {30'd0, rvalid_o}, 32'd1 << p);
    chk({nm, ".err"}, {31'd0, err_o[p]}, {31'd0, exp_err});
    chk({nm, ".rdata"}, rdata_o[p], exp_rd);
    chk({nm, ".strb_off"}, {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
  endtask

  task automatic do_reset();
    req_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        e;
    logic [31:0] rd;
    logic [1:0]  gexp [4];
    logic [1:0]  vexp [4];
    int          diffs;

    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    req_i = '0; we_i = '0; uext_i = '0; size_i = '0; addr_i = '0; wdata_i = '0;
    rst_n = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset.gnt", {30'd0, gnt_o}, 32'd0);
    chk("reset.rvalid", {30'd0, rvalid_o}, 32'd0);
    chk("reset.err", {30'd0, err_o}, 32'd0);
    chk("reset.rdata", rdata_o[0] | rdata_o[1], 32'd0);
    chk("reset.ram_a", ram_a, 32'd0);
    chk("reset.ram_wd", ram_wd, 32'd0);
    chk("reset.strb", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h10000, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h10003, 32'h0, 1'b0, 32'hFFFFFFDE});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h10003, 32'h0, 1'b0, 32'h000000DE});
    tbl.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h10004, 32'hA5A5A5A5, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h10004, 32'hFFFF1234, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h10004, 32'h0, 1'b0, 32'h00001234});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h10004, 32'h0, 1'b0, 32'hA5A51234});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h10001, 32'h00005555, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h10002, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 2'd3, 1'b0, 32'h10000, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h1FFFE, 32'h77777777, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h10000, 32'h0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b0, 2'd1, 1'b0, 32'h10000, 32'h0, 1'b0, 32'hFFFFBEEF});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 32'h1FFFF, 32'h000000C3, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b1, 32'h1FFFF, 32'h0, 1'b0, 32'h000000C3});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h1FFFC, 32'h0, 1'b0, 32'hC3000000});
    tbl.push_back('{1, 1'b0, 2'd1, 1'b0, 32'h1FFFE, 32'h0, 1'b0, 32'hFFFFC300});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0});

    foreach (tbl[i]) begin
      ref_model(tbl[i].we, tbl[i].sz, tbl[i].ux, tbl[i].a, tbl[i].wd, e, rd);
      do_access($sformatf("row%0d", i), tbl[i].p, tbl[i].we, tbl[i].sz, tbl[i].ux,
                tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].rd);
    end
    chk("row10.ram_untouched", {mem[32'h1FFFF], mem[32'h1FFFE]}, 32'h0000C300);

    // Contention: both ports requesting continuously
    do_reset();
    gexp = '{2'b01, 2'b00, 2'b10, 2'b00};
    vexp = '{2'b00, 2'b00, 2'b01, 2'b00};
    @(negedge clk);
    we_i = '0; size_i = '{2'd2, 2'd2}; addr_i = '{32'h10000, 32'h10004}; uext_i = '0;
    req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr.gnt%0d", i), {30'd0, gnt_o}, {30'd0, gexp[i]});
      chk($sformatf("rr.rvalid%0d", i), {30'd0, rvalid_o}, {30'd0, vexp[i]});
      @(negedge clk);
    end
    req_i = 2'b10;
    #1;
    chk("rr.lone_p1", {30'd0, gnt_o}, 32'd2);
    chk("rr.rvalid4", {30'd0, rvalid_o}, 32'd2);
    @(posedge clk);
    #1 req_i = '0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a store's ACCESS cycle
    do_reset();
    @(negedge clk);
    we_i[0] = 1'b1; size_i[0] = 2'd2; addr_i[0] = 32'h10010; wdata_i[0] = 32'h11223344;
    req_i[0] = 1'b1;
    #1;
    chk("rst.gnt", {30'd0, gnt_o}, 32'd1);
    @(posedge clk);
    #1 req_i = '0;
    chk("rst.sw_before", {31'd0, ram_sw}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.strb_drop", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    @(negedge clk);
    chk("rst.no_rvalid", {30'd0, rvalid_o}, 32'd0);
    rst_n = 1'b1;
    we_i = '0; size_i = '{2'd2, 2'd2}; addr_i = '{32'h10000, 32'h10000};
    req_i = 2'b11;
    #1;
    chk("rst.idle_rr0", {30'd0, gnt_o}, 32'd1);
    chk("rst.no_rvalid2", {30'd0, rvalid_o}, 32'd0);
    @(posedge clk);
    #1 req_i = '0;
    repeat (3) @(negedge clk);
    chk("rst.ram_unchanged", {mem[32'h10013], mem[32'h10012], mem[32'h10011], mem[32'h10010]}, 32'd0);

    // Randomised accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      int          p, r;
      logic        we, ux;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      ux = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 6)      a = 32'h10000 + $urandom_range(0, 63);
      else if (r < 9) a = 32'h1FFF0 + $urandom_range(0, 15);
      else            a = $urandom;
      ref_model(we, sz, ux, a, wd, e, rd);
      do_access($sformatf("rnd%0d", i), p, we, sz, ux, a, wd, e, rd);
    end

    diffs = 0;
    for (int i = 32'h10000; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final.mem_diffs", diffs, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
